// File: rtl/mdu_s2.sv
// Final multiply/divide stage: commits multiplies and MTHI/MTLO in one cycle,
// and runs a 32-step restoring divider that stalls the pipeline. Owns HI/LO.
module mdu_s2 #(
    parameter int MDOP_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       s2_AC_i,
    input  logic [31:0]       s2_AD_i,
    input  logic [31:0]       s2_CB_i,
    input  logic [31:0]       s2_BD_i,
    input  logic [MDOP_W-1:0] s2_mduop_i,
    input  logic              s2_res_sign_i,
    input  logic              s2_valid_i,
    input  logic [31:0]       s2_opr1_i,
    input  logic [31:0]       s2_opr2_i,
    input  logic [31:0]       s2_whi_i,
    input  logic [31:0]       s2_wlo_i,
    input  logic              s2_stall_i,
    input  logic              s2_flush_i,
    output logic [31:0]       s2_hi_o,
    output logic [31:0]       s2_lo_o,
    output logic              s2_stall_req_o,
    output logic              s2_busy_o,
    output logic              s2_res_valid_o
);

    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MTHI  = 4;
    localparam int OP_MTLO  = 5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        qsign_q, qsign_d, rsign_q, rsign_d;
    logic        launched_q, launched_d;
    logic        res_valid_q, res_valid_d;

    logic        is_mul, is_div, is_sdiv, live, div_req, launch, div_zero;
    logic [63:0] mag, mul_res;
    logic [31:0] dvd_mag, dvs_mag;
    logic [32:0] shifted, diff;

    assign is_mul  = s2_mduop_i[OP_MULT] | s2_mduop_i[OP_MULTU];
    assign is_sdiv = s2_mduop_i[OP_DIV];
    assign is_div  = s2_mduop_i[OP_DIV] | s2_mduop_i[OP_DIVU];

    // Single-cycle ops only retire while the divider is idle; anything else is ignored.
    assign live     = s2_valid_i & ~s2_flush_i & (state_q == IDLE);
    assign div_req  = live & is_div & ~launched_q;
    assign launch   = div_req & (s2_opr2_i != 32'd0);
    assign div_zero = div_req & (s2_opr2_i == 32'd0);

    assign mag     = {s2_AC_i, 32'b0} + {16'b0, s2_AD_i, 16'b0}
                   + {16'b0, s2_CB_i, 16'b0} + {32'b0, s2_BD_i};
    assign mul_res = s2_res_sign_i ? -mag : mag;

    assign dvd_mag = (is_sdiv & s2_opr1_i[31]) ? -s2_opr1_i : s2_opr1_i;
    assign dvs_mag = (is_sdiv & s2_opr2_i[31]) ? -s2_opr2_i : s2_opr2_i;

    // Remainder < divisor, so a successful trial subtraction always fits in 32 bits.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    assign s2_stall_req_o = launch | ((state_q == BUSY) & ~s2_flush_i);
    assign s2_busy_o      = (state_q != IDLE);
    assign s2_res_valid_o = res_valid_q;
    assign s2_hi_o        = hi_q;
    assign s2_lo_o        = lo_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        launched_d  = launched_q;
        res_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = BUSY;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    quo_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    qsign_d = is_sdiv & (s2_opr1_i[31] ^ s2_opr2_i[31]);
                    rsign_d = is_sdiv & s2_opr1_i[31];
                end
                if (live & is_mul) begin
                    hi_d        = mul_res[63:32];
                    lo_d        = mul_res[31:0];
                    res_valid_d = 1'b1;
                end
                if (live & s2_mduop_i[OP_MTHI]) begin
                    hi_d        = s2_whi_i;
                    res_valid_d = 1'b1;
                end
                if (live & s2_mduop_i[OP_MTLO]) begin
                    lo_d        = s2_wlo_i;
                    res_valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (s2_flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = diff[32] ? shifted[31:0] : diff[31:0];
                    quo_d = {quo_q[30:0], ~diff[32]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!s2_flush_i) begin
                    lo_d        = qsign_q ? -quo_q : quo_q;
                    hi_d        = rsign_q ? -rem_q : rem_q;
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // launched marks the held div as retired; it drops once the stage moves on.
        if (launch | div_zero) launched_d = 1'b1;
        if (!s2_stall_i || s2_flush_i) launched_d = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
            cnt_q       <= 5'd0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            launched_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            launched_q  <= launched_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_mdu_s2.sv
// Self-checking bench for mdu_s2: expected HI/LO come from plain 64-bit
// multiply/divide arithmetic on the original operands.
module tb_mdu_s2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s2_AC_i, s2_AD_i, s2_CB_i, s2_BD_i;
    logic [5:0]  s2_mduop_i;
    logic        s2_res_sign_i, s2_valid_i;
    logic [31:0] s2_opr1_i, s2_opr2_i, s2_whi_i, s2_wlo_i;
    logic        s2_stall_i, s2_flush_i;
    logic [31:0] s2_hi_o, s2_lo_o;
    logic        s2_stall_req_o, s2_busy_o, s2_res_valid_o;

    logic        force_stall, auto_stall;
    int          n_checks, n_fail;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    // The pipeline holds whenever the stage asks, plus any externally forced stall.
    assign s2_stall_i = force_stall | (auto_stall & s2_stall_req_o);

    mdu_s2 #(.MDOP_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .s2_AC_i(s2_AC_i), .s2_AD_i(s2_AD_i), .s2_CB_i(s2_CB_i), .s2_BD_i(s2_BD_i),
        .s2_mduop_i(s2_mduop_i), .s2_res_sign_i(s2_res_sign_i), .s2_valid_i(s2_valid_i),
        .s2_opr1_i(s2_opr1_i), .s2_opr2_i(s2_opr2_i),
        .s2_whi_i(s2_whi_i), .s2_wlo_i(s2_wlo_i),
        .s2_stall_i(s2_stall_i), .s2_flush_i(s2_flush_i),
        .s2_hi_o(s2_hi_o), .s2_lo_o(s2_lo_o),
        .s2_stall_req_o(s2_stall_req_o), .s2_busy_o(s2_busy_o),
        .s2_res_valid_o(s2_res_valid_o)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        if (sgn) return longint'($signed(a)) * longint'($signed(b));
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           output logic [31:0] q, output logic [31:0] r);
        longint sq, sr;
        if (sgn) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            q = sq[31:0];
            r = sr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        s2_valid_i = 1'b0; s2_mduop_i = 6'b0; s2_flush_i = 1'b0; s2_res_sign_i = 1'b0;
        s2_AC_i = 32'd0; s2_AD_i = 32'd0; s2_CB_i = 32'd0; s2_BD_i = 32'd0;
        s2_opr1_i = 32'd0; s2_opr2_i = 32'd0; s2_whi_i = 32'd0; s2_wlo_i = 32'd0;
    endtask

    // Stage-1 emulation: partial products of operand magnitudes.
    task automatic drive_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        s2_AC_i = ma[31:16] * mb[31:16];
        s2_AD_i = ma[31:16] * mb[15:0];
        s2_CB_i = mb[31:16] * ma[15:0];
        s2_BD_i = ma[15:0] * mb[15:0];
        s2_res_sign_i = sgn & (a[31] ^ b[31]);
        s2_mduop_i = sgn ? 6'b000001 : 6'b000010;
        s2_valid_i = 1'b1;
    endtask

    // Runs one divide with the pipeline stalling on request; returns after the commit edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           output int stalls, output logic busy_done);
        s2_opr1_i = a; s2_opr2_i = b;
        s2_mduop_i = sgn ? 6'b000100 : 6'b001000;
        s2_valid_i = 1'b1;
        #1;
        stalls = 0;
        while (s2_stall_req_o && stalls < 100) begin
            stalls++;
            tick();
        end
        busy_done = s2_busy_o;
        tick();
        s2_valid_i = 1'b0; s2_mduop_i = 6'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; force_stall = 1'b0; auto_stall = 1'b1;
        idle_inputs();
        tick(); tick();
        n_checks++; if (s2_hi_o !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", s2_hi_o); end
        n_checks++; if (s2_lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", s2_lo_o); end
        n_checks++; if (s2_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall_req: got %b expected 0", s2_stall_req_o); end
        n_checks++; if (s2_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", s2_busy_o); end
        n_checks++; if (s2_res_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", s2_res_valid_o); end
        rst_n = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_mult_directed;
        s2_valid_i = 1'b1; s2_mduop_i = 6'b000001; s2_res_sign_i = 1'b1;
        s2_AC_i = 32'd0; s2_AD_i = 32'd0; s2_CB_i = 32'd0; s2_BD_i = 32'd15;
        tick();
        n_checks++; if (s2_hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h expected ffffffff", s2_hi_o); end
        n_checks++; if (s2_lo_o !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_neg_lo: got %h expected fffffff1", s2_lo_o); end
        n_checks++; if (s2_res_valid_o !== 1'b1) begin n_fail++; $display("FAIL mult_res_valid: got %b expected 1", s2_res_valid_o); end
        idle_inputs();
        tick();
        n_checks++; if (s2_res_valid_o !== 1'b0) begin n_fail++; $display("FAIL mult_pulse_width: got %b expected 0", s2_res_valid_o); end
        s2_valid_i = 1'b1; s2_mduop_i = 6'b000010; s2_res_sign_i = 1'b0;
        s2_AC_i = 32'hFFFE0001; s2_AD_i = 32'hFFFE0001; s2_CB_i = 32'hFFFE0001; s2_BD_i = 32'hFFFE0001;
        tick();
        n_checks++; if (s2_hi_o !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h expected fffffffe", s2_hi_o); end
        n_checks++; if (s2_lo_o !== 32'h00000001) begin n_fail++; $display("FAIL multu_max_lo: got %h expected 00000001", s2_lo_o); end
        idle_inputs();
        tick();
        exp_hi = 32'hFFFFFFFE; exp_lo = 32'h00000001;
    endtask

    task automatic test_mult_random;
        logic [31:0] a, b;
        logic [63:0] p;
        bit sgn;
        for (int i = 0; i < 24; i++) begin
            a = (i == 0) ? 32'h80000000 : $urandom;
            b = (i == 0) ? 32'h80000000 : ((i % 5 == 1) ? $urandom_range(0, 3) : $urandom);
            sgn = $urandom_range(0, 1);
            drive_mul(a, b, sgn);
            tick();
            p = ref_mul(a, b, sgn);
            n_checks++; if (s2_hi_o !== p[63:32]) begin n_fail++; $display("FAIL mult_rand_hi: a=%h b=%h s=%0d got %h expected %h", a, b, sgn, s2_hi_o, p[63:32]); end
            n_checks++; if (s2_lo_o !== p[31:0]) begin n_fail++; $display("FAIL mult_rand_lo: a=%h b=%h s=%0d got %h expected %h", a, b, sgn, s2_lo_o, p[31:0]); end
            exp_hi = p[63:32]; exp_lo = p[31:0];
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mt;
        bit to_hi;
        for (int i = 0; i < 10; i++) begin
            to_hi = $urandom_range(0, 1);
            s2_whi_i = $urandom; s2_wlo_i = $urandom;
            s2_mduop_i = to_hi ? 6'b010000 : 6'b100000;
            s2_valid_i = 1'b1;
            if (to_hi) exp_hi = s2_whi_i; else exp_lo = s2_wlo_i;
            tick();
            n_checks++; if (s2_hi_o !== exp_hi) begin n_fail++; $display("FAIL mt_hi: got %h expected %h", s2_hi_o, exp_hi); end
            n_checks++; if (s2_lo_o !== exp_lo) begin n_fail++; $display("FAIL mt_lo: got %h expected %h", s2_lo_o, exp_lo); end
            n_checks++; if (s2_res_valid_o !== 1'b1) begin n_fail++; $display("FAIL mt_res_valid: got %b expected 1", s2_res_valid_o); end
        end
        // Flushed MT and multiply must not write.
        idle_inputs();
        s2_whi_i = ~exp_hi; s2_mduop_i = 6'b010000; s2_valid_i = 1'b1; s2_flush_i = 1'b1;
        tick();
        drive_mul(32'd7, 32'd9, 1'b0); s2_flush_i = 1'b1;
        tick();
        n_checks++; if (s2_hi_o !== exp_hi) begin n_fail++; $display("FAIL flush_nowrite_hi: got %h expected %h", s2_hi_o, exp_hi); end
        n_checks++; if (s2_lo_o !== exp_lo) begin n_fail++; $display("FAIL flush_nowrite_lo: got %h expected %h", s2_lo_o, exp_lo); end
        n_checks++; if (s2_res_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_nowrite_rv: got %b expected 0", s2_res_valid_o); end
        idle_inputs();
        tick();
    endtask

    task automatic check_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] q, r;
        int stalls;
        logic busy_done;
        ref_div(a, b, sgn, q, r);
        run_div(a, b, sgn, stalls, busy_done);
        n_checks++; if (stalls != 33) begin n_fail++; $display("FAIL div_stall_cycles: a=%h b=%h got %0d expected 33", a, b, stalls); end
        n_checks++; if (busy_done !== 1'b1) begin n_fail++; $display("FAIL div_busy_in_done: got %b expected 1", busy_done); end
        n_checks++; if (s2_lo_o !== q) begin n_fail++; $display("FAIL div_quot: a=%h b=%h s=%0d got %h expected %h", a, b, sgn, s2_lo_o, q); end
        n_checks++; if (s2_hi_o !== r) begin n_fail++; $display("FAIL div_rem: a=%h b=%h s=%0d got %h expected %h", a, b, sgn, s2_hi_o, r); end
        n_checks++; if (s2_res_valid_o !== 1'b1 || s2_busy_o !== 1'b0) begin n_fail++; $display("FAIL div_commit_flags: rv=%b busy=%b expected 1/0", s2_res_valid_o, s2_busy_o); end
        exp_hi = r; exp_lo = q;
    endtask

    task automatic test_div;
        logic [31:0] a, b;
        logic [63:0] p;
        bit sgn;
        check_div(32'hFFFFFFF9, 32'h00000002, 1'b1);
        check_div(32'hFFFFFFF9, 32'h00000002, 1'b0);
        check_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
        // Random divides, each followed back-to-back by a multiply.
        for (int i = 0; i < 6; i++) begin
            sgn = $urandom_range(0, 1);
            a = $urandom;
            b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            if (i == 3) b = -b;
            if (b == 32'd0) b = 32'd3;
            check_div(a, b, sgn);
            a = $urandom; b = $urandom;
            drive_mul(a, b, sgn);
            tick();
            p = ref_mul(a, b, sgn);
            n_checks++; if ({s2_hi_o, s2_lo_o} !== p) begin n_fail++; $display("FAIL mult_after_div: got %h%h expected %h", s2_hi_o, s2_lo_o, p); end
            exp_hi = p[63:32]; exp_lo = p[31:0];
            idle_inputs();
        end
        tick();
    endtask

    task automatic test_div_held;
        int launches, pulses;
        logic prev_busy;
        force_stall = 1'b1;
        s2_opr1_i = 32'hFFFFFFF9; s2_opr2_i = 32'd2; s2_mduop_i = 6'b000100; s2_valid_i = 1'b1;
        launches = 0; pulses = 0; prev_busy = s2_busy_o;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s2_busy_o && !prev_busy) launches++;
            if (s2_res_valid_o) pulses++;
            prev_busy = s2_busy_o;
        end
        n_checks++; if (launches != 1) begin n_fail++; $display("FAIL held_launches: got %0d expected 1", launches); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL held_pulses: got %0d expected 1", pulses); end
        n_checks++; if (s2_lo_o !== 32'hFFFFFFFD || s2_hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL held_result: got hi=%h lo=%h expected ffffffff/fffffffd", s2_hi_o, s2_lo_o); end
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD;
        idle_inputs();
        force_stall = 1'b0;
        tick();
    endtask

    task automatic test_flush;
        s2_mduop_i = 6'b010000; s2_whi_i = 32'h12345678; s2_valid_i = 1'b1;
        tick();
        s2_mduop_i = 6'b100000; s2_wlo_i = 32'h9ABCDEF0;
        tick();
        exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;
        s2_opr1_i = 32'd100; s2_opr2_i = 32'd7; s2_mduop_i = 6'b000100;
        tick();
        repeat (10) tick();
        n_checks++; if (s2_busy_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b expected 1", s2_busy_o); end
        s2_flush_i = 1'b1;
        #1;
        n_checks++; if (s2_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall_req: got %b expected 0", s2_stall_req_o); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (s2_busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got busy %b expected 0", s2_busy_o); end
        n_checks++; if (s2_hi_o !== exp_hi || s2_lo_o !== exp_lo) begin n_fail++; $display("FAIL flush_hilo: got %h/%h expected %h/%h", s2_hi_o, s2_lo_o, exp_hi, exp_lo); end
        n_checks++; if (s2_res_valid_o !== 1'b0 || s2_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_flags: rv=%b stall=%b expected 0/0", s2_res_valid_o, s2_stall_req_o); end
        tick();
    endtask

    task automatic test_div_zero;
        s2_opr1_i = 32'd123; s2_opr2_i = 32'd0; s2_mduop_i = 6'b000100; s2_valid_i = 1'b1;
        #1;
        n_checks++; if (s2_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL divzero_stall: got %b expected 0", s2_stall_req_o); end
        tick();
        n_checks++; if (s2_busy_o !== 1'b0 || s2_res_valid_o !== 1'b0) begin n_fail++; $display("FAIL divzero_flags: busy=%b rv=%b expected 0/0", s2_busy_o, s2_res_valid_o); end
        n_checks++; if (s2_hi_o !== exp_hi || s2_lo_o !== exp_lo) begin n_fail++; $display("FAIL divzero_hilo: got %h/%h expected %h/%h", s2_hi_o, s2_lo_o, exp_hi, exp_lo); end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset;
        s2_opr1_i = 32'd1000; s2_opr2_i = 32'd3; s2_mduop_i = 6'b001000; s2_valid_i = 1'b1;
        tick();
        repeat (5) tick();
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_checks++; if (s2_hi_o !== 32'd0 || s2_lo_o !== 32'd0) begin n_fail++; $display("FAIL async_reset_hilo: got %h/%h expected 0/0", s2_hi_o, s2_lo_o); end
        n_checks++; if (s2_busy_o !== 1'b0 || s2_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_fsm: busy=%b stall=%b expected 0/0", s2_busy_o, s2_stall_req_o); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mult_directed();
        test_mult_random();
        test_mt();
        test_div();
        test_div_held();
        test_flush();
        test_div_zero();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_s2.md
Name: mdu_s2

Overview:
Second, final stage of the multiply/divide unit, and the consumer of the stage-1 partial-product registers.
- Multiplies: sums the four 16x16 partial products into a 64-bit magnitude, applies the result sign and commits to HI/LO in one cycle.
- DIV/DIVU: runs a 32-iteration restoring divider FSM and holds the pipeline via a stall request.
- MTHI/MTLO: writes the supplied data into HI/LO.
- Owns the architectural HI/LO registers.

Parameters:
- MDOP_W, 6, width of the mduop field. One-hot encoding: [0] MULT, [1] MULTU, [2] DIV, [3] DIVU, [4] MTHI, [5] MTLO.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s2_AC_i, s2_AD_i, s2_CB_i, s2_BD_i  in  32 each  unsigned partial products of operand magnitudes (A/C high halves, B/D low halves)
- s2_mduop_i  in  MDOP_W  one-hot op, zero when bubble
- s2_res_sign_i  in  1  negate multiply result
- s2_valid_i  in  1  stage-1 output holds a live op
- s2_opr1_i, s2_opr2_i  in  32 each  raw operands (dividend, divisor)
- s2_whi_i, s2_wlo_i  in  32 each  MTHI/MTLO data
- s2_stall_i  in  1  pipeline held this cycle (may include our own request)
- s2_flush_i  in  1  kill the op in this stage
- s2_hi_o, s2_lo_o  out  32 each  architectural HI/LO
- s2_stall_req_o  out  1  divider needs the pipeline held
- s2_busy_o  out  1  FSM not IDLE
- s2_res_valid_o  out  1  one-cycle pulse: HI/LO updated at this edge

Behaviour:
- Reset, asynchronous:
  - hi=lo=0
  - FSM IDLE, launched=0, counter=0
  - s2_stall_req_o=0, s2_busy_o=0, s2_res_valid_o=0
- Multiply:
  - mag = {AC,32'b0} + {16'b0,AD,16'b0} + {16'b0,CB,16'b0} + {32'b0,BD}, 64-bit, carries kept.
  - res = res_sign ? ~mag+1 : mag.
  - On valid & MULT/MULTU & !flush at an edge: hi<=res[63:32], lo<=res[31:0], res_valid pulses.
  - Repeated commit while stalled is idempotent and permitted.
- MTHI/MTLO:
  - valid & !flush writes hi<=s2_whi_i or lo<=s2_wlo_i at the edge. The other register is unchanged.
  - res_valid pulses.
- Divider FSM, states IDLE, BUSY, DONE:
  - Launch condition in IDLE: valid & (DIV|DIVU) & !launched & !flush & divisor!=0.
  - At launch, dividend and divisor magnitudes are latched. Signed magnitudes are taken only for DIV.
  - Latched sign bits: qsign = op1[31]^op2[31], rsign = op1[31] (DIV only).
  - At launch: set launched, go BUSY, counter=0.
  - s2_stall_req_o is combinationally high in the launch cycle, during all of BUSY, and low in DONE.
  - BUSY: one restoring step per cycle (shift remainder:quotient left by 1, trial-subtract divisor, set quotient bit if no borrow). counter increments each cycle. After the 32nd step (counter==31) go DONE.
  - DONE: lo<=qsign?-q:q, hi<=rsign?-r:r at the edge leaving DONE. res_valid pulses. Next state IDLE.
  - Latency: stall_req high for 33 cycles (launch + 32 BUSY); HI/LO visible in the cycle after DONE.
  - Divisor==0: no launch, no stall. HI/LO unchanged. launched is set (op treated as retired).
  - Iterations and DONE proceed regardless of s2_stall_i.
- launched flag:
  - Cleared at any edge with s2_stall_i==0 (pipeline advanced) or s2_flush_i==1.
  - Prevents relaunching the same div while the stage-1 register is still held.
- Flush:
  - In BUSY or DONE: abort to IDLE, HI/LO unchanged, no res_valid. stall_req deasserts combinationally that cycle.
  - Flush with a multiply or MT op: no write.
- Simultaneous events:
  - A multiply/MT arriving while BUSY cannot occur (pipeline stalled). If it does with valid=1, it is ignored.
  - Flush wins over DONE commit.
- Bubble (valid=0 or mduop=0): no state change.

Test Plan:
- MULT 0xFFFFFFFD x 0x00000005: AC=AD=CB=0, BD=15, res_sign=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1 after one edge, res_valid one pulse.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: AC=AD=CB=BD=0xFFFE0001, sign 0 -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 / 0x00000002, stall_i driven from stall_req -> stall_req high exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> LO=0x7FFFFFFC, HI=0x1.
- Launched DIV held in stage with s2_stall_i forced high 10 cycles beyond DONE -> exactly one launch, one res_valid pulse.
- Flush at BUSY cycle 10 of DIV 100/7 -> IDLE next cycle, HI/LO keep prior values, stall_req low.
- DIV by zero -> no stall, HI/LO unchanged. Separately, rst_n low mid-BUSY -> HI=LO=0, IDLE immediately (asynchronous).
